udsp_data_mem: RTL

// Responder side of the uDSP data-memory interface: 2^DAW x DWW word store that

---
 rtl/udsp_data_mem.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/udsp_data_mem.sv
// ---------------------------------------------------------------------------
// udsp_data_mem
//
// Responder side of the uDSP data-memory interface. This block holds a
// 2^DAW x DWW word store and serves the core through two registered read
// ports (A, B) and one write port (W). It also sequences frames: a host
// loads data over a valid/ready port and pulses go. The block then issues
// start to the core, waits for the program plus the pipeline drain, and
// pulses frame_done.
//
// Configuration macro: UDSP_MEM_WR_BYPASS_EN
//   When defined, a read of an address that is written in the same cycle
//   returns the new data (write-first). When undefined, it returns the old
//   contents (read-first).
//
// Ports
//   clk          clock, all logic on the rising edge
//   reset_n      synchronous active-low reset
//   addrA/dataA  core read port A; data is registered, 1-cycle latency
//   addrB/dataB  core read port B; data is registered, 1-cycle latency
//   addrW/dataW  core write address and data
//   writeEn      core write enable; has priority over host writes
//   start        one-cycle pulse to the core's start input
//   go           host request to run one frame
//   busy         high while a frame is in progress
//   frame_done   one-cycle pulse once the frame has fully drained
//   host_valid   host request valid
//   host_ready   host request accepted when host_valid & host_ready
//   host_we      host request kind: 1 = write, 0 = read
//   host_addr    host address
//   host_wdata   host write data
//   host_rvalid  one-cycle pulse; host read data is valid
//   host_rdata   host read data; holds until the next read returns
// ---------------------------------------------------------------------------
module udsp_data_mem #(
  parameter int unsigned DAW      = 10,
  parameter int unsigned DWW      = 36,
  parameter int unsigned PROG_LEN = 512,
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [DAW-1:0] addrA,
  output logic [DWW-1:0] dataA,
  input  logic [DAW-1:0] addrB,
  output logic [DWW-1:0] dataB,
  input  logic [DAW-1:0] addrW,
  input  logic [DWW-1:0] dataW,
  input  logic           writeEn,
  output logic           start,
  input  logic           go,
  output logic           busy,
  output logic           frame_done,
  input  logic           host_valid,
  output logic           host_ready,
  input  logic           host_we,
  input  logic [DAW-1:0] host_addr,
  input  logic [DWW-1:0] host_wdata,
  output logic           host_rvalid,
  output logic [DWW-1:0] host_rdata
);

  localparam int unsigned DEPTH     = 1 << DAW;
  localparam int unsigned FRAME_LEN = PROG_LEN + PIPE_LAT;
  localparam int unsigned CNT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             start_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  logic [DWW-1:0]   mem [DEPTH];

  logic             host_acc;
  logic             host_wr;
  logic             host_rd;
  logic             wr_en;
  logic [DAW-1:0]   wr_addr;
  logic [DWW-1:0]   wr_data;

  // Host is open only while idle or finishing. A go request or a core write
  // closes it for that cycle.
  assign host_ready = ((state == S_IDLE) || (state == S_DONE)) && !go && !writeEn;
  assign host_acc   = host_valid && host_ready;
  assign host_wr    = host_acc && host_we;
  assign host_rd    = host_acc && !host_we;

  // A core write and a host write never occur in the same cycle, because
  // host_ready is low whenever writeEn is high. One shared write port is
  // therefore enough.
  assign wr_en   = writeEn || host_wr;
  assign wr_addr = writeEn ? addrW : host_addr;
  assign wr_data = writeEn ? dataW : host_wdata;

  // Word store. It has no reset, so its contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read value for one port, including the same-cycle collision policy.
  function automatic logic [DWW-1:0] rd_word(input logic [DAW-1:0] a);
`ifdef UDSP_MEM_WR_BYPASS_EN
    if (wr_en && (wr_addr == a)) begin
      return wr_data;
    end
`endif
    return mem[a];
  endfunction

  // Registered read data for core ports A/B and for the host port.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dataA       <= '0;
      dataB       <= '0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      dataA       <= rd_word(addrA);
      dataB       <= rd_word(addrB);
      host_rvalid <= host_rd;
      if (host_rd) begin
        host_rdata <= rd_word(host_addr);
      end
    end
  end

  // Frame sequencing: next state, cycle counter and registered outputs.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start_nxt = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_nxt   = '0;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        // Hold at the last count so the counter never wraps within a frame.
        if (cnt == CNT_LAST) begin
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // Outputs are decoded from the next state, so their registered copies
    // line up with the state they describe.
    start_nxt = (state_nxt == S_LAUNCH);
    busy_nxt  = (state_nxt == S_LAUNCH) || (state_nxt == S_RUN);
    done_nxt  = (state_nxt == S_DONE);
  end

  // State, counter and output registers. Reset aborts any frame silently.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      start      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      start      <= start_nxt;
      busy       <= busy_nxt;
      frame_done <= done_nxt;
    end
  end

endmodule
